// File: rtl/potato1_pkg.sv
// Shared definitions for the Potato-1 datapath sequencer.
// Holds the Command bit positions, the sequencer state encoding and the
// default datapath widths.
package potato1_pkg;

  localparam int unsigned PC_WIDTH_DEF   = 8;
  localparam int unsigned TAPE_AW_DEF    = 8;
  localparam int unsigned CELL_WIDTH_DEF = 8;

  // Command word bit positions; bit 0 is PC_INC.
  localparam int unsigned CMD_PC_INC = 0;
  localparam int unsigned CMD_PC_DEC = 1;
  localparam int unsigned CMD_X_INC  = 2;
  localparam int unsigned CMD_X_DEC  = 3;
  localparam int unsigned CMD_A_INC  = 4;
  localparam int unsigned CMD_A_DEC  = 5;
  localparam int unsigned CMD_PUT    = 6;
  localparam int unsigned CMD_GET    = 7;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    RUN      = 2'd1,
    WAIT_OUT = 2'd2,
    WAIT_IN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/potato1_io_bridge.sv
// IO handshake bridge for the Potato-1 sequencer.
// Decides when a PUT/GET starts, drives the valid/ready byte stream while the
// sequencer sits in WAIT_OUT/WAIT_IN, and keeps the IoDone flag that stops a
// stalled command from being executed twice.
// Ports:
//   Clock, Reset        clock and synchronous active-high reset
//   state               current sequencer state
//   put_cmd, get_cmd    PUT / GET bits of the current command
//   pc_step             PC_INC or PC_DEC set in the current command
//   eff_a               effective accumulator, latched as the output byte
//   InValid / InReady   input byte handshake
//   OutData / OutValid / OutReady  output byte handshake
//   io_start, io_put    IO op accepted this cycle, and whether it is a PUT
//   out_fire, in_fire   handshake completes this cycle
//   io_done             IO op complete (drives IOReady)
module potato1_io_bridge
  import potato1_pkg::*;
#(
  parameter int unsigned CELL_WIDTH = CELL_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  seq_state_e            state,
  input  logic                  put_cmd,
  input  logic                  get_cmd,
  input  logic                  pc_step,
  input  logic [CELL_WIDTH-1:0] eff_a,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [CELL_WIDTH-1:0] OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  io_start,
  output logic                  io_put,
  output logic                  out_fire,
  output logic                  in_fire,
  output logic                  io_done
);

  logic                  io_done_q;
  logic [CELL_WIDTH-1:0] out_data_q;
  logic                  io_req;
  logic                  retire;

  always_comb begin
    io_req   = put_cmd | get_cmd;
    // An instruction is retired once the CPU moves the PC or drops the IO bits.
    retire   = pc_step | ~io_req;
    io_start = (state == RUN) && io_req && !io_done_q && !Reset;
    io_put   = put_cmd;
    OutValid = (state == WAIT_OUT) && !Reset;
    InReady  = (state == WAIT_IN) && !Reset;
    out_fire = OutValid && OutReady;
    in_fire  = InValid && InReady;
    io_done  = io_done_q && !Reset;
    OutData  = out_data_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      io_done_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (out_fire || in_fire) begin
        io_done_q <= 1'b1;
      end else if ((state == RUN) && retire) begin
        io_done_q <= 1'b0;
      end
      if (io_start && io_put) begin
        out_data_q <= eff_a;
      end
    end
  end

endmodule

// File: rtl/potato1_datapath_sequencer.sv
// Potato-1 datapath sequencer.
// Executes the control unit's 8-bit command word against PC, tape pointer X,
// accumulator A (cached copy of tape cell X) and a single-port synchronous
// tape RAM. After reset it zeroes the whole tape before accepting commands.
// Ports:
//   Clock, Reset         clock and synchronous active-high reset
//   Command              {GET,PUT,A_DEC,A_INC,X_DEC,X_INC,PC_DEC,PC_INC}
//   ProgAddr             program memory address (PC)
//   State                zero flag of the effective accumulator
//   IOReady              IO op complete (level)
//   Busy                 tape clear in progress
//   MemAddr/MemWData/MemWe/MemRe/MemRData  tape RAM port, 1-cycle read latency
//   InData/InValid/InReady                 input byte stream
//   OutData/OutValid/OutReady              output byte stream
module potato1_datapath_sequencer
  import potato1_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned TAPE_AW    = TAPE_AW_DEF,
  parameter int unsigned CELL_WIDTH = CELL_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            Command,
  output logic [PC_WIDTH-1:0]   ProgAddr,
  output logic                  State,
  output logic                  IOReady,
  output logic                  Busy,
  output logic [TAPE_AW-1:0]    MemAddr,
  output logic [CELL_WIDTH-1:0] MemWData,
  output logic                  MemWe,
  output logic                  MemRe,
  input  logic [CELL_WIDTH-1:0] MemRData,
  input  logic [CELL_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [CELL_WIDTH-1:0] OutData,
  output logic                  OutValid,
  input  logic                  OutReady
);

  seq_state_e            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [TAPE_AW-1:0]    x_q, x_d;
  logic [TAPE_AW-1:0]    clr_q, clr_d;
  logic [CELL_WIDTH-1:0] a_q, a_d;
  logic                  load_pending_q, load_pending_d;
  logic [CELL_WIDTH-1:0] eff_a;

  logic io_start, io_put, out_fire, in_fire, io_done;
  logic pc_inc, pc_dec, x_inc, x_dec, a_inc, a_dec;

  potato1_io_bridge #(
    .CELL_WIDTH (CELL_WIDTH)
  ) u_io_bridge (
    .Clock    (Clock),
    .Reset    (Reset),
    .state    (state_q),
    .put_cmd  (Command[CMD_PUT]),
    .get_cmd  (Command[CMD_GET]),
    .pc_step  (pc_inc | pc_dec),
    .eff_a    (eff_a),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutData  (OutData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .io_start (io_start),
    .io_put   (io_put),
    .out_fire (out_fire),
    .in_fire  (in_fire),
    .io_done  (io_done)
  );

  always_comb begin
    pc_inc = Command[CMD_PC_INC];
    pc_dec = Command[CMD_PC_DEC];
    x_inc  = Command[CMD_X_INC];
    x_dec  = Command[CMD_X_DEC];
    a_inc  = Command[CMD_A_INC];
    a_dec  = Command[CMD_A_DEC];
  end

  always_comb begin
    // The RAM read issued by an X move lands one cycle later; forward it.
    eff_a          = load_pending_q ? MemRData : a_q;
    state_d        = state_q;
    pc_d           = pc_q;
    x_d            = x_q;
    clr_d          = clr_q;
    // A pending load always resolves into A the following cycle.
    a_d            = eff_a;
    load_pending_d = 1'b0;
    MemAddr        = x_q;
    MemWData       = '0;
    MemWe          = 1'b0;
    MemRe          = 1'b0;

    case (state_q)
      CLEAR: begin
        MemWe    = 1'b1;
        MemAddr  = clr_q;
        clr_d    = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (pc_inc && !pc_dec) begin
          pc_d = pc_q + 1'b1;
        end else if (pc_dec && !pc_inc) begin
          pc_d = pc_q - 1'b1;
        end

        // X moves take the single RAM port for a read, so A bits are dropped.
        if (x_inc || x_dec) begin
          x_d            = x_inc ? x_q + 1'b1 : x_q - 1'b1;
          MemRe          = 1'b1;
          MemAddr        = x_d;
          load_pending_d = 1'b1;
        end else if (a_inc || a_dec) begin
          a_d      = a_inc ? eff_a + 1'b1 : eff_a - 1'b1;
          MemWe    = 1'b1;
          MemWData = a_d;
        end

        if (io_start) begin
          state_d = io_put ? WAIT_OUT : WAIT_IN;
        end
      end

      WAIT_OUT: begin
        if (out_fire) begin
          state_d = RUN;
        end
      end

      WAIT_IN: begin
        if (in_fire) begin
          a_d      = InData;
          MemWe    = 1'b1;
          MemWData = InData;
          state_d  = RUN;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase

    if (Reset) begin
      MemWe = 1'b0;
      MemRe = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= CLEAR;
      pc_q           <= '0;
      x_q            <= '0;
      a_q            <= '0;
      clr_q          <= '0;
      load_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      x_q            <= x_d;
      a_q            <= a_d;
      clr_q          <= clr_d;
      load_pending_q <= load_pending_d;
    end
  end

  always_comb begin
    ProgAddr = pc_q;
    State    = (eff_a == '0);
    IOReady  = io_done;
    Busy     = (state_q == CLEAR) || Reset;
  end

endmodule
